// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: funct3 codes,
// fault causes, FSM state encoding and the request fault decoder.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    CAUSE_OK      = 2'd0,
    CAUSE_MISAL   = 2'd1,
    CAUSE_RANGE   = 2'd2,
    CAUSE_ILLEGAL = 2'd3
  } cause_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Illegal beats misaligned beats out-of-range.
  function automatic cause_t decode_cause(input logic        we,
                                          input logic [2:0]  funct3,
                                          input logic [31:0] addr,
                                          input logic [31:0] mem_bytes);
    logic illegal;
    logic misal;
    illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7) ||
              (we && (funct3 > F3_W));
    misal   = ((funct3 == F3_W) && (addr[1:0] != 2'b00)) ||
              (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]);
    if (illegal)                 return CAUSE_ILLEGAL;
    else if (misal)              return CAUSE_MISAL;
    else if (addr >= mem_bytes)  return CAUSE_RANGE;
    else                         return CAUSE_OK;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-port bundle of the load/store unit.
// slave = the LSU itself, master = pipeline plus RAM side.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  logic [31:0] mem_raddr;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_cause,
           mem_raddr, mem_re, mem_waddr, mem_we, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_cause,
           mem_raddr, mem_re, mem_waddr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store byte/half merge
// into the old RAM word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it for loads.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   load_o = {24'h0, byte_sel};
      F3_HU:   load_o = {16'h0, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Replace only the addressed byte/half of the old word for stores.
  always_comb begin
    merged_o = word_i;
    case (funct3_i)
      F3_B: begin
        case (lane_i)
          2'd0:    merged_o = {word_i[31:8], wdata_i[7:0]};
          2'd1:    merged_o = {word_i[31:16], wdata_i[7:0], word_i[7:0]};
          2'd2:    merged_o = {word_i[31:24], wdata_i[7:0], word_i[15:0]};
          default: merged_o = {wdata_i[7:0], word_i[23:0]};
        endcase
      end
      F3_H:    merged_o = lane_i[1] ? {wdata_i[15:0], word_i[15:0]}
                                    : {word_i[31:16], wdata_i[15:0]};
      F3_W:    merged_o = wdata_i;
      default: merged_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a word-wide RAM with
// combinational read and synchronous write. IDLE -> EXEC -> RESP.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst,
  lsu_mem_ctrl_if.slave     bus
);

  state_t      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  cause_t      cause_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  cause_t      resp_cause_q;

  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic [31:0] resp_rdata_d;
  logic        exec_ok;

  lsu_align u_align (
    .funct3_i (funct3_q),
    .lane_i   (addr_q[1:0]),
    .word_i   (bus.mem_rdata),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merged_o (merged_word)
  );

  // RAM strobes decode straight from the state register, so an async reset
  // in EXEC removes mem_we before the next edge can commit a write.
  always_comb begin
    exec_ok        = (state_q == S_EXEC) && (cause_q == CAUSE_OK);
    bus.mem_re     = exec_ok && (!we_q || (funct3_q != F3_W));
    bus.mem_we     = exec_ok && we_q;
    bus.mem_raddr  = {addr_q[31:2], 2'b00};
    bus.mem_waddr  = {addr_q[31:2], 2'b00};
    bus.mem_wdata  = bus.mem_we ? merged_word : 32'h0;
    bus.req_ready  = (state_q == S_IDLE);
    resp_rdata_d   = (!we_q && (cause_q == CAUSE_OK)) ? load_data : 32'h0;
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_cause = resp_cause_q;

  // Control FSM with request latch and registered response.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset clears every register here, including the request latch, so address outputs read 0.
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      cause_q      <= CAUSE_OK;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_cause_q <= CAUSE_OK;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            cause_q  <= decode_cause(bus.req_we, bus.req_funct3, bus.req_addr,
                                     32'(MEM_BYTES));
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= resp_rdata_d;
          resp_cause_q <= cause_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: behavioural word RAM, byte-level
// reference model and a response scoreboard.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.MEM_BYTES(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural RAM: combinational read, write on the rising edge.
  logic [31:0] ram [128];
  assign bus.mem_rdata = bus.mem_re ? ram[bus.mem_raddr[8:2]] : 32'h0;
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_waddr[8:2]] <= bus.mem_wdata;

  // Reference memory kept as bytes, independent of the RAM word layout.
  logic [7:0] ref_b [512];

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    int a;
    logic [7:0] b0, b1, b2, b3;
    e.rdata = 32'h0;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 > 3'd2))       e.cause = 2'd3;
    else if ((f3 == 3'd2 && addr[1:0] != 2'b00) ||
             ((f3 == 3'd1 || f3 == 3'd5) && addr[0]))                      e.cause = 2'd1;
    else if (addr >= 32'd512)                                              e.cause = 2'd2;
    else                                                                   e.cause = 2'd0;
    if (e.cause == 2'd0) begin
      a = int'(addr[8:0]);
      if (we) begin
        ref_b[a] = wd[7:0];
        if (f3 != 3'd0) ref_b[a+1] = wd[15:8];
        if (f3 == 3'd2) begin
          ref_b[a+2] = wd[23:16];
          ref_b[a+3] = wd[31:24];
        end
      end else begin
        b0 = ref_b[a];
        b1 = (a + 1 < 512) ? ref_b[a+1] : 8'h0;
        b2 = (a + 2 < 512) ? ref_b[a+2] : 8'h0;
        b3 = (a + 3 < 512) ? ref_b[a+3] : 8'h0;
        case (f3)
          3'd0:    e.rdata = {{24{b0[7]}}, b0};
          3'd4:    e.rdata = {24'h0, b0};
          3'd1:    e.rdata = {{16{b1[7]}}, b1, b0};
          3'd5:    e.rdata = {16'h0, b1, b0};
          default: e.rdata = {b3, b2, b1, b0};
        endcase
      end
    end
    return e;
  endfunction

  // One full transaction: accept, EXEC strobes, RESP pulse and scoreboard pop.
  task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    exp_t e;
    exp_t got;
    bit   accepted;
    logic exp_re, exp_we;
    accepted = 1'b0;
    e = model(we, f3, addr, wd);
    exp_q.push_back(e);
    exp_we = we && (e.cause == 2'd0);
    exp_re = (e.cause == 2'd0) && (!we || f3 != 3'd2);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    for (int i = 0; i < 8; i++) begin
      if (bus.req_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL %s accept: req_ready never high within 8 cycles", name);
      bus.req_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    // EXEC cycle
    checks++;
    if (bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s early_resp: resp_valid=%b expected 0", name, bus.resp_valid);
    end
    checks++;
    if (bus.mem_re !== exp_re) begin
      errors++;
      $display("FAIL %s mem_re: got %b expected %b", name, bus.mem_re, exp_re);
    end
    checks++;
    if (bus.mem_we !== exp_we) begin
      errors++;
      $display("FAIL %s mem_we: got %b expected %b", name, bus.mem_we, exp_we);
    end
    if (exp_re || exp_we) begin
      checks++;
      if (bus.mem_raddr !== {addr[31:2], 2'b00} || bus.mem_waddr !== {addr[31:2], 2'b00}) begin
        errors++;
        $display("FAIL %s mem_addr: raddr=%h waddr=%h expected %h", name,
                 bus.mem_raddr, bus.mem_waddr, {addr[31:2], 2'b00});
      end
    end
    // RESP cycle: two cycles after accept
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s latency: resp_valid=%b expected 1 two cycles after accept", name, bus.resp_valid);
    end
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL %s strobes_in_resp: re=%b we=%b expected 0", name, bus.mem_re, bus.mem_we);
    end
    got = exp_q.pop_front();
    checks++;
    if (bus.resp_rdata !== got.rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h expected %h", name, bus.resp_rdata, got.rdata);
    end
    checks++;
    if (bus.resp_cause !== got.cause) begin
      errors++;
      $display("FAIL %s cause: got %0d expected %0d", name, bus.resp_cause, got.cause);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s pulse_end: resp_valid=%b req_ready=%b expected 0/1", name,
               bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_cause !== 2'd0 ||
        bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0 ||
        bus.mem_raddr !== 32'h0 || bus.mem_waddr !== 32'h0) begin
      errors++;
      $display("FAIL %s: rv=%b rd=%h rc=%0d re=%b we=%b wd=%h ra=%h wa=%h expected all 0", name,
               bus.resp_valid, bus.resp_rdata, bus.resp_cause, bus.mem_re, bus.mem_we,
               bus.mem_wdata, bus.mem_raddr, bus.mem_waddr);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b expected 1", name, bus.req_ready);
    end
  endtask

  task automatic check_ram(input string name, input int widx, input logic [31:0] expv);
    checks++;
    if (ram[widx] !== expv) begin
      errors++;
      $display("FAIL %s: ram word got %h expected %h", name, ram[widx], expv);
    end
  endtask

  task automatic test_reset();
    #1;
    check_outputs_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word();
    run_req("sw_40", 1'b1, 3'd2, 32'h40, 32'hDEADBEEF);
    check_ram("sw_40_ram", 16, 32'hDEADBEEF);
    run_req("lw_40", 1'b0, 3'd2, 32'h40, 32'h0);
  endtask

  task automatic test_byte_half();
    run_req("sb_41", 1'b1, 3'd0, 32'h41, 32'hFFFFFF12);
    check_ram("sb_41_ram", 16, 32'hDEAD12EF);
    run_req("lb_41",  1'b0, 3'd0, 32'h41, 32'h0);
    run_req("lb_43",  1'b0, 3'd0, 32'h43, 32'h0);
    run_req("lbu_43", 1'b0, 3'd4, 32'h43, 32'h0);
    run_req("sh_42", 1'b1, 3'd1, 32'h42, 32'h12348001);
    check_ram("sh_42_ram", 16, 32'h800112EF);
    run_req("lh_42",  1'b0, 3'd1, 32'h42, 32'h0);
    run_req("lhu_42", 1'b0, 3'd5, 32'h42, 32'h0);
  endtask

  task automatic test_faults();
    run_req("lw_41_misal", 1'b0, 3'd2, 32'h41, 32'h0);
    run_req("sh_43_misal", 1'b1, 3'd1, 32'h43, 32'hAAAA5555);
    check_ram("sh_43_ram_unchanged", 16, 32'h800112EF);
    run_req("lw_200_range", 1'b0, 3'd2, 32'h200, 32'h0);
    run_req("sb_f3_3_illegal", 1'b1, 3'd3, 32'h40, 32'h77);
    run_req("f3_6_prio", 1'b0, 3'd6, 32'h201, 32'h0);
    run_req("sbu_illegal", 1'b1, 3'd4, 32'h40, 32'h99);
    check_ram("faults_ram_unchanged", 16, 32'h800112EF);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   pulses = 0;
    int   first = -1;
    int   second = -1;
    exp_q.push_back(model(1'b0, 3'd2, 32'h40, 32'h0));
    exp_q.push_back(model(1'b0, 3'd2, 32'h40, 32'h0));
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd2;
    bus.req_addr   = 32'h40;
    bus.req_wdata  = 32'h0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 6) bus.req_valid = 1'b0;
      if (bus.resp_valid === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        else           second = k;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_resp: response at cycle %0d with empty scoreboard", k);
        end else begin
          e = exp_q.pop_front();
          if (bus.resp_rdata !== e.rdata || bus.resp_cause !== e.cause) begin
            errors++;
            $display("FAIL b2b_data: got %h/%0d expected %h/%0d", bus.resp_rdata,
                     bus.resp_cause, e.rdata, e.cause);
          end
        end
      end
    end
    checks++;
    if (pulses != 2 || first != 2 || second != 5) begin
      errors++;
      $display("FAIL b2b_timing: pulses=%0d at %0d,%0d expected 2 at 2,5", pulses, first, second);
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: ready=%b resp_valid=%b expected 1/0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_reset_in_exec();
    run_req("sw_44", 1'b1, 3'd2, 32'h44, 32'hCAFEF00D);
    check_ram("sw_44_ram", 17, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h44;
    bus.req_wdata  = 32'h55;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_ready: got %b expected 1", bus.req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rst_exec_we_before: got %b expected 1", bus.mem_we);
    end
    rst = 1'b1;
    #1;
    check_outputs_zero("rst_exec_outputs");
    @(posedge clk);
    @(negedge clk);
    check_ram("rst_exec_ram_unchanged", 17, 32'hCAFEF00D);
    rst = 1'b0;
    run_req("lw_44_after_rst", 1'b0, 3'd2, 32'h44, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    test_reset();
    test_word();
    test_byte_half();
    test_faults();
    test_back_to_back();
    test_reset_in_exec();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
